data_ram_resp: RTL and testbench

- Data-memory responder at the far end of the MEM-stage load/store bus.
- Accepts the request signals the MEM stage drives: ce, we, addr, sel and write data.
- Performs byte-lane writes and whole-word reads into a word-organised RAM, with a programmable number of wait states.
- Holds the pipeline through ctrl with a stall request until read data is valid or the write has committed.

---
 rtl/data_ram_resp_pkg.sv | 28 ++
 rtl/data_ram_resp_ram.sv | 26 ++
 rtl/data_ram_resp.sv | 125 ++++++++++++
 tb/tb_data_ram_resp.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/data_ram_resp_pkg.sv
// Shared types and constants for the MEM-stage data-memory responder.
// Imported by the FSM top and the byte-enable RAM.
package data_ram_resp_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StWait = 2'b01,
      StDone = 2'b10
   } state_e;

   localparam int unsigned CntW = 4;

   localparam int unsigned LaneW    = 8;
   localparam int unsigned Lane3Lsb = 24;
   localparam int unsigned Lane2Lsb = 16;
   localparam int unsigned Lane1Lsb = 8;
   localparam int unsigned Lane0Lsb = 0;

   localparam logic        ChipEnable  = 1'b1;
   localparam logic        WriteEnable = 1'b1;
   localparam logic [31:0] ZeroWord    = 32'h0000_0000;

   // Any set bit above the word-index field means the access misses the RAM.
   function automatic logic out_of_range(input logic [31:0] addr, input int unsigned addr_w);
      return (addr >> (addr_w + 2)) != ZeroWord;
   endfunction

endpackage

// File: rtl/data_ram_resp_ram.sv
// Single-port synchronous RAM with four byte-lane write enables and a registered read port.
// No reset on the array or read register so it maps onto block RAM.
module data_ram_resp_ram
   import data_ram_resp_pkg::*;
#(
   parameter int unsigned ADDR_W = 10
) (
   input  logic              clk,
   input  logic [ADDR_W-1:0] addr,
   input  logic [3:0]        be,
   input  logic [31:0]       wdata,
   input  logic              re,
   output logic [31:0]       rdata
);

   logic [31:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (be[3]) mem[addr][Lane3Lsb +: LaneW] <= wdata[Lane3Lsb +: LaneW];
      if (be[2]) mem[addr][Lane2Lsb +: LaneW] <= wdata[Lane2Lsb +: LaneW];
      if (be[1]) mem[addr][Lane1Lsb +: LaneW] <= wdata[Lane1Lsb +: LaneW];
      if (be[0]) mem[addr][Lane0Lsb +: LaneW] <= wdata[Lane0Lsb +: LaneW];
      if (re)    rdata <= mem[addr];
   end

endmodule

// File: rtl/data_ram_resp.sv
// Data-memory responder: accepts MEM-stage load/store requests, inserts WAIT_CYCLES wait
// states, commits on the edge entering DONE and stalls the pipeline until then.
module data_ram_resp
   import data_ram_resp_pkg::*;
#(
   parameter int unsigned ADDR_W      = 10,
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_ce_i,
   input  logic        mem_we_i,
   input  logic [31:0] mem_addr_i,
   input  logic [3:0]  mem_sel_i,
   input  logic [31:0] mem_data_i,
   output logic [31:0] mem_data_o,
   output logic        stallreq_o,
   output logic        ack_o,
   output logic        err_o
);

   localparam logic [CntW-1:0] WaitInit = CntW'(WAIT_CYCLES);
   localparam logic [CntW-1:0] CntOne   = CntW'(1);

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            we_q;
   logic [31:0]     addr_q;
   logic [3:0]      sel_q;
   logic [31:0]     data_q;
   logic            err_q;
   logic            data_zero_q;
   logic [31:0]     ram_rdata;

   logic            accept;
   logic            commit;
   logic            c_we;
   logic [31:0]     c_addr;
   logic [3:0]      c_sel;
   logic [31:0]     c_data;
   logic            c_oor;

   assign accept = (state_q == StIdle) && (mem_ce_i == ChipEnable);

   // With zero wait states the commit edge is the accept edge, so use the live bus in IDLE.
   assign c_we   = (state_q == StIdle) ? mem_we_i   : we_q;
   assign c_addr = (state_q == StIdle) ? mem_addr_i : addr_q;
   assign c_sel  = (state_q == StIdle) ? mem_sel_i  : sel_q;
   assign c_data = (state_q == StIdle) ? mem_data_i : data_q;
   assign c_oor  = out_of_range(c_addr, ADDR_W);
   assign commit = (state_d == StDone) && (state_q != StDone);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (mem_ce_i == ChipEnable) begin
               cnt_d   = WaitInit;
               state_d = (WAIT_CYCLES > 0) ? StWait : StDone;
            end
         end
         StWait: begin
            if (mem_ce_i != ChipEnable) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else if (cnt_q == CntOne) begin
               state_d = StDone;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - CntOne;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         we_q        <= 1'b0;
         addr_q      <= ZeroWord;
         sel_q       <= 4'b0000;
         data_q      <= ZeroWord;
         err_q       <= 1'b0;
         data_zero_q <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            we_q   <= mem_we_i;
            addr_q <= mem_addr_i;
            sel_q  <= mem_sel_i;
            data_q <= mem_data_i;
            err_q  <= c_oor;
         end
         // Out-of-range reads return zero without touching the RAM read register.
         if (commit && (c_we != WriteEnable)) data_zero_q <= c_oor;
      end
   end

   data_ram_resp_ram #(
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk   (clk),
      .addr  (c_addr[ADDR_W+1:2]),
      .be    ((commit && (c_we == WriteEnable) && !c_oor) ? c_sel : 4'b0000),
      .wdata (c_data),
      .re    (commit && (c_we != WriteEnable) && !c_oor),
      .rdata (ram_rdata)
   );

   assign mem_data_o = data_zero_q ? ZeroWord : ram_rdata;
   assign stallreq_o = rst && (accept || (state_q == StWait));
   assign ack_o      = (state_q == StDone);
   assign err_o      = (state_q == StDone) && err_q;

endmodule

// File: tb/tb_data_ram_resp.sv
// Self-checking bench: three responders (1, 3 and 0 wait states) on a shared request bus,
// directed vector table, reset/abort sequences and randomized traffic against a word model.
module tb_data_ram_resp;

   logic        clk;
   logic        rst;
   logic [2:0]  ce;
   logic        we;
   logic [31:0] addr;
   logic [3:0]  sel;
   logic [31:0] wdata;
   logic [31:0] rd [3];
   logic [2:0]  stall;
   logic [2:0]  ack;
   logic [2:0]  err;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] ref_mem  [3][16];
   logic [31:0] ref_data [3];

   typedef struct {
      int          k;
      logic        we;
      logic [31:0] addr;
      logic [3:0]  sel;
      logic [31:0] wdata;
      int          abort_at;
      logic [31:0] exp_data;
      logic        exp_err;
   } vec_t;

   vec_t vecs [$];

   data_ram_resp #(.ADDR_W(10), .WAIT_CYCLES(1)) u_dut1 (
      .clk(clk), .rst(rst), .mem_ce_i(ce[0]), .mem_we_i(we), .mem_addr_i(addr),
      .mem_sel_i(sel), .mem_data_i(wdata), .mem_data_o(rd[0]), .stallreq_o(stall[0]),
      .ack_o(ack[0]), .err_o(err[0])
   );
   data_ram_resp #(.ADDR_W(10), .WAIT_CYCLES(3)) u_dut3 (
      .clk(clk), .rst(rst), .mem_ce_i(ce[1]), .mem_we_i(we), .mem_addr_i(addr),
      .mem_sel_i(sel), .mem_data_i(wdata), .mem_data_o(rd[1]), .stallreq_o(stall[1]),
      .ack_o(ack[1]), .err_o(err[1])
   );
   data_ram_resp #(.ADDR_W(10), .WAIT_CYCLES(0)) u_dut0 (
      .clk(clk), .rst(rst), .mem_ce_i(ce[2]), .mem_we_i(we), .mem_addr_i(addr),
      .mem_sel_i(sel), .mem_data_i(wdata), .mem_data_o(rd[2]), .stallreq_o(stall[2]),
      .ack_o(ack[2]), .err_o(err[2])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   function automatic int wc_of(input int k);
      return (k == 0) ? 1 : ((k == 1) ? 3 : 0);
   endfunction

   task automatic chk(input string name, input int k, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s dut%0d @%0t: got %h required %h", name, k, $time, act, exp);
      end
   endtask

   // One request on responder k; abort_at>0 drops ce in that wait cycle.
   task automatic access(input int k, input logic w, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] d, input int abort_at, input logic [31:0] exp_data,
                         input logic exp_err);
      int wc;
      wc = wc_of(k);
      @(negedge clk);
      ce = 3'b000; ce[k] = 1'b1; we = w; addr = a; sel = s; wdata = d;
      #1;
      chk("stall_req", k, 32'(stall[k]), 32'd1);
      chk("ack_req", k, 32'(ack[k]), 32'd0);
      for (int c = 1; c <= wc; c++) begin
         @(negedge clk);
         if (c == abort_at) begin
            ce[k] = 1'b0;
            #1;
            chk("stall_abort", k, 32'(stall[k]), 32'd1);
            chk("ack_abort", k, 32'(ack[k]), 32'd0);
            @(negedge clk);
            #1;
            chk("stall_after_abort", k, 32'(stall[k]), 32'd0);
            chk("ack_after_abort", k, 32'(ack[k]), 32'd0);
            chk("data_after_abort", k, rd[k], exp_data);
            return;
         end
         #1;
         chk("stall_wait", k, 32'(stall[k]), 32'd1);
         chk("ack_wait", k, 32'(ack[k]), 32'd0);
      end
      @(negedge clk);
      #1;
      chk("stall_done", k, 32'(stall[k]), 32'd0);
      chk("ack_done", k, 32'(ack[k]), 32'd1);
      chk("err_done", k, 32'(err[k]), 32'(exp_err));
      chk("data_done", k, rd[k], exp_data);
   endtask

   task automatic idle_cycle();
      @(negedge clk);
      ce = 3'b000;
      #1;
      for (int k = 0; k < 3; k++) begin
         chk("stall_idle", k, 32'(stall[k]), 32'd0);
         chk("ack_idle", k, 32'(ack[k]), 32'd0);
      end
   endtask

   task automatic chk_reset_outputs();
      for (int k = 0; k < 3; k++) begin
         chk("rst_stall", k, 32'(stall[k]), 32'd0);
         chk("rst_ack", k, 32'(ack[k]), 32'd0);
         chk("rst_err", k, 32'(err[k]), 32'd0);
         chk("rst_data", k, rd[k], 32'h0);
      end
   endtask

   initial begin
      logic [31:0] a, d, e;
      logic [3:0]  s;
      logic        w, oor;
      int          wd, ab;

      rst = 1'b0; ce = 3'b111; we = 1'b0; addr = '0; sel = '0; wdata = '0;
      #3;
      chk_reset_outputs();
      @(negedge clk);
      ce = 3'b000;
      @(negedge clk);
      rst = 1'b1;

      // Directed vectors: k, we, addr, sel, wdata, abort_at, exp mem_data_o, exp err.
      vecs.push_back(vec_t'{0, 1'b1, 32'h10, 4'b1111, 32'hDEADBEEF, 0, 32'h0,        1'b0});
      vecs.push_back(vec_t'{0, 1'b0, 32'h10, 4'b1111, 32'h0,        0, 32'hDEADBEEF, 1'b0});
      vecs.push_back(vec_t'{0, 1'b1, 32'h11, 4'b0100, 32'h5A5A5A5A, 0, 32'hDEADBEEF, 1'b0});
      vecs.push_back(vec_t'{0, 1'b0, 32'h10, 4'b1111, 32'h0,        0, 32'hDE5ABEEF, 1'b0});
      vecs.push_back(vec_t'{0, 1'b0, 32'h13, 4'b0001, 32'h0,        0, 32'hDE5ABEEF, 1'b0});
      vecs.push_back(vec_t'{0, 1'b1, 32'h12, 4'b0011, 32'h12341234, 0, 32'hDE5ABEEF, 1'b0});
      vecs.push_back(vec_t'{0, 1'b0, 32'h10, 4'b1111, 32'h0,        0, 32'hDE5A1234, 1'b0});
      vecs.push_back(vec_t'{0, 1'b1, 32'h10, 4'b0000, 32'hFFFFFFFF, 0, 32'hDE5A1234, 1'b0});
      vecs.push_back(vec_t'{0, 1'b0, 32'h10, 4'b1111, 32'h0,        0, 32'hDE5A1234, 1'b0});
      vecs.push_back(vec_t'{0, 1'b1, 32'h00, 4'b1111, 32'h11111111, 0, 32'hDE5A1234, 1'b0});
      vecs.push_back(vec_t'{0, 1'b0, 32'h0001_0000, 4'b1111, 32'h0, 0, 32'h0,         1'b1});
      vecs.push_back(vec_t'{0, 1'b1, 32'h0001_0000, 4'b1111, 32'hBAD0BAD0, 0, 32'h0,  1'b1});
      vecs.push_back(vec_t'{0, 1'b0, 32'h00, 4'b1111, 32'h0,        0, 32'h11111111, 1'b0});
      vecs.push_back(vec_t'{0, 1'b0, 32'h10, 4'b1111, 32'h0,        0, 32'hDE5A1234, 1'b0});
      vecs.push_back(vec_t'{1, 1'b1, 32'h10, 4'b1111, 32'hCAFEF00D, 0, 32'h0,        1'b0});
      vecs.push_back(vec_t'{1, 1'b1, 32'h10, 4'b1111, 32'h0BADBEEF, 2, 32'h0,        1'b0});
      vecs.push_back(vec_t'{1, 1'b0, 32'h10, 4'b1111, 32'h0,        2, 32'h0,        1'b0});
      vecs.push_back(vec_t'{1, 1'b0, 32'h10, 4'b1111, 32'h0,        0, 32'hCAFEF00D, 1'b0});
      vecs.push_back(vec_t'{2, 1'b1, 32'h10, 4'b1111, 32'h01020304, 0, 32'h0,        1'b0});
      vecs.push_back(vec_t'{2, 1'b1, 32'h14, 4'b1111, 32'hA0B0C0D0, 0, 32'h0,        1'b0});
      vecs.push_back(vec_t'{2, 1'b0, 32'h10, 4'b1111, 32'h0,        0, 32'h01020304, 1'b0});
      vecs.push_back(vec_t'{2, 1'b0, 32'h14, 4'b1111, 32'h0,        0, 32'hA0B0C0D0, 1'b0});

      foreach (vecs[i]) begin
         access(vecs[i].k, vecs[i].we, vecs[i].addr, vecs[i].sel, vecs[i].wdata,
                vecs[i].abort_at, vecs[i].exp_data, vecs[i].exp_err);
      end
      idle_cycle();
      ref_data[0] = 32'hDE5A1234;
      ref_data[1] = 32'hCAFEF00D;
      ref_data[2] = 32'hA0B0C0D0;

      // Reset in the middle of a pending write: outputs drop at once, the write is lost.
      access(1, 1'b1, 32'h20, 4'b1111, 32'h13572468, 0, ref_data[1], 1'b0);
      @(negedge clk);
      ce = 3'b010; we = 1'b1; addr = 32'h20; sel = 4'b1111; wdata = 32'hFFFF0000;
      @(negedge clk);
      #1;
      chk("stall_pre_reset", 1, 32'(stall[1]), 32'd1);
      #2;
      rst = 1'b0;
      #1;
      chk_reset_outputs();
      ce = 3'b000;
      for (int k = 0; k < 3; k++) ref_data[k] = 32'h0;
      @(negedge clk);
      rst = 1'b1;
      access(1, 1'b0, 32'h20, 4'b1111, 32'h0, 0, 32'h13572468, 1'b0);
      ref_data[1] = 32'h13572468;

      // Randomized traffic against the word model.
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 16; i++) begin
            d = $urandom;
            access(k, 1'b1, 32'(i) << 2, 4'b1111, d, 0, ref_data[k], 1'b0);
            ref_mem[k][i] = d;
         end
         for (int n = 0; n < 60; n++) begin
            w   = 1'($urandom_range(0, 1));
            wd  = int'($urandom_range(0, 15));
            a   = (32'(wd) << 2) | 32'($urandom_range(0, 3));
            s   = 4'($urandom_range(0, 15));
            d   = $urandom;
            oor = ($urandom_range(0, 7) == 0);
            if (oor) a = a | (32'h1 << $urandom_range(12, 31));
            ab  = 0;
            if (wc_of(k) > 0 && $urandom_range(0, 7) == 0) ab = int'($urandom_range(1, wc_of(k)));
            if (ab != 0) begin
               access(k, w, a, s, d, ab, ref_data[k], 1'b0);
            end else if (w) begin
               access(k, 1'b1, a, s, d, 0, ref_data[k], oor);
               if (!oor) begin
                  for (int b = 0; b < 4; b++) begin
                     if (s[b]) ref_mem[k][wd][b*8 +: 8] = d[b*8 +: 8];
                  end
               end
            end else begin
               e = oor ? 32'h0 : ref_mem[k][wd];
               access(k, 1'b0, a, s, d, 0, e, oor);
               ref_data[k] = e;
            end
            if ($urandom_range(0, 3) == 0) idle_cycle();
         end
      end
      idle_cycle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
